// File: rtl/fpu16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : fpu16_pkg                                                          |
// | Purpose : Shared types and binary16 constants for the half-precision FPU.    |
// |           norm_state_t enumerates the normalise/round stage controller.     |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package fpu16_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } norm_state_t;

  localparam int          EXP_BIAS = 15;
  localparam logic [4:0]  EXP_MAX  = 5'h1F;
  localparam logic [15:0] QNAN     = 16'h7E00;
  localparam logic [15:0] PINF     = 16'h7C00;

endpackage
`default_nettype wire

// File: rtl/half_fp_norm_round_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : half_fp_norm_round_if                                            |
// | Purpose   : Operand (upstream) and result (downstream) valid/ready buses    |
// |             of the normalise/round stage.                                   |
// | Ports     : master - drives operands and out_ready (producer/consumer side) |
// |             slave  - the normalise/round stage itself                       |
// | Rev       : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface half_fp_norm_round_if #(
  parameter int EXP_W  = 7,
  parameter int PROD_W = 22
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic                    in_sign;
  logic signed [EXP_W-1:0] in_exp;
  logic [PROD_W-1:0]       in_mant;
  logic                    in_special;
  logic [15:0]             in_special_val;
  logic                    out_valid;
  logic                    out_ready;
  logic [15:0]             result;
  logic                    flag_overflow;
  logic                    flag_underflow;
  logic                    flag_inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_special, in_special_val, out_ready,
    input  in_ready, out_valid, result, flag_overflow, flag_underflow, flag_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_special, in_special_val, out_ready,
    output in_ready, out_valid, result, flag_overflow, flag_underflow, flag_inexact
  );

endinterface
`default_nettype wire

// File: rtl/half_fp_round_rne.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : half_fp_round_rne                                                  |
// | Purpose : Combinational round-to-nearest-even and binary16 packing of a     |
// |           normalised (or denormalised) significand.                          |
// | Ports   : m       - significand, binary point between bits 20 and 19        |
// |           e       - signed biased exponent (>= 1 on entry)                   |
// |           s       - sign                                                     |
// |           sticky  - OR of all bits already shifted out                       |
// |           result  - packed binary16                                          |
// |           flag_*  - overflow / underflow / inexact                           |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module half_fp_round_rne
  import fpu16_pkg::*;
#(
  parameter int PROD_W = 22,
  parameter int E_W    = 8
) (
  input  wire logic [PROD_W-1:0]     m,
  input  wire logic signed [E_W-1:0] e,
  input  wire logic                  s,
  input  wire logic                  sticky,
  output logic [15:0]                result,
  output logic                       flag_overflow,
  output logic                       flag_underflow,
  output logic                       flag_inexact
);

  logic [10:0]          kept;
  logic                 lsb;
  logic                 guard;
  logic                 st;
  logic                 inc;
  logic [11:0]          sum;
  logic [10:0]          kept_r;
  logic signed [E_W:0]  e_r;
  logic [4:0]           exp_f;

  always_comb begin
    kept  = m[PROD_W-2 -: 11];
    lsb   = m[PROD_W-12];
    guard = m[PROD_W-13];
    st    = sticky | (|m[PROD_W-14:0]);
    inc   = guard & (st | lsb);
    sum   = {1'b0, kept} + {11'd0, inc};

    // Rounding 1.111..1 up carries into bit 11: renormalise by one place.
    if (sum[11]) begin
      kept_r = sum[11:1];
      e_r    = (E_W+1)'(e) + (E_W+1)'(1);
    end else begin
      kept_r = sum[10:0];
      e_r    = (E_W+1)'(e);
    end

    // A subnormal that rounds up to 0x400 picks up exponent field 1 here.
    exp_f          = kept_r[10] ? e_r[4:0] : 5'd0;
    result         = {s, exp_f, kept_r[9:0]};
    flag_overflow  = 1'b0;
    flag_inexact   = guard | st;
    flag_underflow = (exp_f == 5'd0) & (guard | st);

    if (e_r >= (E_W+1)'(int'(EXP_MAX))) begin
      result         = {s, PINF[14:0]};
      flag_overflow  = 1'b1;
      flag_inexact   = 1'b1;
      flag_underflow = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/half_fp_norm_round.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : half_fp_norm_round                                                 |
// | Purpose : Post-multiply stage of the binary16 multiplier. Normalises the    |
// |           raw 22-bit product one bit per cycle (left or right), denormalises|
// |           into the subnormal range collecting sticky, then rounds RNE and   |
// |           packs. One operation in flight; special results bypass.          |
// | Ports   : clk, rst (async, active high)                                      |
// |           bus (slave) - in_valid/in_ready operand side with sign, exponent, |
// |                         product and special bypass; out_valid/out_ready     |
// |                         result side with packed result and three flags.     |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module half_fp_norm_round
  import fpu16_pkg::*;
#(
  parameter int EXP_W  = 7,
  parameter int PROD_W = 22
) (
  input  wire logic          clk,
  input  wire logic          rst,
  half_fp_norm_round_if.slave bus
);

  // One bit of headroom: a right shift from the largest input exponent
  // must not wrap before the overflow compare sees it.
  localparam int E_W = EXP_W + 1;

  norm_state_t             state_q, state_d;
  logic [PROD_W-1:0]       m_q, m_d;
  logic signed [E_W-1:0]   e_q, e_d;
  logic                    s_q, s_d;
  logic                    sticky_q, sticky_d;
  logic [15:0]             result_q, result_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;
  logic                    inx_q, inx_d;

  logic [15:0]             rnd_result;
  logic                    rnd_ovf;
  logic                    rnd_unf;
  logic                    rnd_inx;

  half_fp_round_rne #(
    .PROD_W (PROD_W),
    .E_W    (E_W)
  ) u_round (
    .m              (m_q),
    .e              (e_q),
    .s              (s_q),
    .sticky         (sticky_q),
    .result         (rnd_result),
    .flag_overflow  (rnd_ovf),
    .flag_underflow (rnd_unf),
    .flag_inexact   (rnd_inx)
  );

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    e_d      = e_q;
    s_d      = s_q;
    sticky_d = sticky_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    inx_d    = inx_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_special) begin
            result_d = bus.in_special_val;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
            inx_d    = 1'b0;
            state_d  = OUT;
          end else begin
            m_d      = bus.in_mant;
            e_d      = E_W'(bus.in_exp);
            s_d      = bus.in_sign;
            sticky_d = 1'b0;
            state_d  = NORM;
          end
        end
      end

      NORM: begin
        // Right shift for a product >= 2.0, or to climb out of the
        // subnormal exponent range; left shift toward a leading 1 at bit 20
        // but never below exponent 1.
        if (m_q[PROD_W-1] || (e_q < E_W'(1))) begin
          m_d      = m_q >> 1;
          sticky_d = sticky_q | m_q[0];
          e_d      = e_q + E_W'(1);
        end else if (!m_q[PROD_W-2] && (m_q != '0) && (e_q > E_W'(1))) begin
          m_d = m_q << 1;
          e_d = e_q - E_W'(1);
        end else begin
          state_d = ROUND;
        end
      end

      ROUND: begin
        result_d = rnd_result;
        ovf_d    = rnd_ovf;
        unf_d    = rnd_unf;
        inx_d    = rnd_inx;
        state_d  = OUT;
      end

      OUT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      m_q      <= '0;
      e_q      <= '0;
      s_q      <= 1'b0;
      sticky_q <= 1'b0;
      result_q <= 16'h0000;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      e_q      <= e_d;
      s_q      <= s_d;
      sticky_q <= sticky_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inx_q    <= inx_d;
    end
  end

  assign bus.in_ready       = (state_q == IDLE);
  assign bus.out_valid      = (state_q == OUT);
  assign bus.result         = result_q;
  assign bus.flag_overflow  = ovf_q;
  assign bus.flag_underflow = unf_q;
  assign bus.flag_inexact   = inx_q;

endmodule
`default_nettype wire

// File: tb/tb_half_fp_norm_round.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_half_fp_norm_round                                              |
// | Purpose : Self-checking bench for half_fp_norm_round. A value-level model    |
// |           (exact scaling + RNE on integers) predicts each result; a single |
// |           compare process checks every cycle out_valid is high, and the     |
// |           directed vectors carry hand-computed literals that pin the model. |
// | Rev     : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_half_fp_norm_round;

  localparam int EXP_W  = 7;
  localparam int PROD_W = 22;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  half_fp_norm_round_if #(.EXP_W(EXP_W), .PROD_W(PROD_W)) bus ();

  half_fp_norm_round #(.EXP_W(EXP_W), .PROD_W(PROD_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] expv;
  } chk_t;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  fl;
    int          lat;
    bit          lit_en;
    logic [15:0] lit_res;
    logic [2:0]  lit_fl;
    int          lit_lat;
    int          acc_cyc;
  } exp_t;

  chk_t chk_q[$];
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Literal expectations for the operation currently being offered.
  bit          lit_en;
  logic [15:0] lit_res;
  logic [2:0]  lit_fl;
  int          lit_lat;

  // Value of the operand is m * 2^(e - 35). Choose the binary16 quantum
  // (2^(eq-25), eq >= 1), scale to an integer q, round half to even.
  // Latency counts cycles from the accept cycle to the first out_valid
  // cycle: 1 for bypass, 3 + k otherwise (k = exponent distance moved).
  function automatic void model(input logic s, input logic signed [6:0] e,
                                input logic [21:0] m, input logic sp,
                                input logic [15:0] spv,
                                output logic [15:0] res, output logic [2:0] fl,
                                output int lat);
    int     ei, p, eb, ebq, r, k;
    longint q, rem, half;
    bit     inx, up;
    logic [4:0] expf;
    ei = e;
    if (sp) begin
      res = spv; fl = 3'b000; lat = 1;
      return;
    end
    if (m == 22'd0) begin
      k   = (ei < 1) ? (1 - ei) : 0;
      res = {s, 15'h0000}; fl = 3'b000; lat = 3 + k;
      return;
    end
    p = 21;
    while (m[p] == 1'b0) p--;
    eb  = ei + p - 20;
    ebq = (eb < 1) ? 1 : eb;
    k   = (ebq > ei) ? (ebq - ei) : (ei - ebq);
    lat = 3 + k;
    r   = p - 10 + ebq - eb;
    if (r > 0) begin
      q    = longint'(m) >> r;
      rem  = longint'(m) & ((64'sd1 <<< r) - 1);
      half = 64'sd1 <<< (r - 1);
    end else begin
      q    = longint'(m) <<< (-r);
      rem  = 0;
      half = 1;
    end
    inx = (rem != 0);
    up  = (rem > half) || ((rem == half) && q[0]);
    if (up) q = q + 1;
    if (q == 2048) begin
      q   = 1024;
      ebq = ebq + 1;
    end
    if (ebq >= 31) begin
      res = {s, 5'h1F, 10'h000};
      fl  = 3'b101;
    end else begin
      expf = (q >= 1024) ? ebq[4:0] : 5'd0;
      res  = {s, expf, q[9:0]};
      fl   = {1'b0, (expf == 5'd0) && inx, inx};
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic post(input string name, input logic [31:0] act, input logic [31:0] expv);
    chk_t c;
    c.name = name; c.act = act; c.expv = expv;
    chk_q.push_back(c);
  endtask

  // Single compare process: owns the counters and the expectation queue.
  initial begin : monitor
    chk_t c;
    exp_t e;
    bit   seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        check(c.name, c.act, c.expv);
      end
      if (rst) begin
        exp_q.delete();
        seen = 1'b0;
      end else begin
        if (bus.out_valid) begin
          check("in_ready_while_out_valid", 32'(bus.in_ready), 32'd0);
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 32'd1, 32'd0);
          end else begin
            e = exp_q[0];
            check("result", 32'(bus.result), 32'(e.res));
            check("flags_ovf_unf_inx",
                  32'({bus.flag_overflow, bus.flag_underflow, bus.flag_inexact}), 32'(e.fl));
            if (!seen) begin
              check("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
              if (e.lit_en) begin
                check("model_result_vs_literal", 32'(e.res), 32'(e.lit_res));
                check("model_flags_vs_literal", 32'(e.fl), 32'(e.lit_fl));
                check("latency_vs_literal", 32'(cyc - e.acc_cyc), 32'(e.lit_lat));
              end
              seen = 1'b1;
            end
            if (bus.out_ready) begin
              void'(exp_q.pop_front());
              seen = 1'b0;
            end
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          model(bus.in_sign, bus.in_exp, bus.in_mant, bus.in_special, bus.in_special_val,
                e.res, e.fl, e.lat);
          e.lit_en  = lit_en;
          e.lit_res = lit_res;
          e.lit_fl  = lit_fl;
          e.lit_lat = lit_lat;
          e.acc_cyc = cyc;
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic offer(input logic s, input int e, input logic [21:0] m,
                       input bit sp, input logic [15:0] spv);
    int n;
    bus.in_sign        = s;
    bus.in_exp         = 7'(e);
    bus.in_mant        = m;
    bus.in_special     = sp;
    bus.in_special_val = spv;
    bus.in_valid       = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) post("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_op(input logic s, input int e, input logic [21:0] m,
                       input bit sp, input logic [15:0] spv,
                       input bit len, input logic [15:0] lres, input logic [2:0] lfl,
                       input int llat, input int hold);
    int n;
    lit_en  = len;
    lit_res = lres;
    lit_fl  = lfl;
    lit_lat = llat;
    bus.out_ready = (hold == 0);
    offer(s, e, m, sp, spv);
    n = 0;
    while (!bus.out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.out_valid) post("out_valid_timeout", 32'd1, 32'd0);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin : driver
    bus.in_valid       = 1'b0;
    bus.in_sign        = 1'b0;
    bus.in_exp         = '0;
    bus.in_mant        = '0;
    bus.in_special     = 1'b0;
    bus.in_special_val = '0;
    bus.out_ready      = 1'b1;
    lit_en = 1'b0; lit_res = '0; lit_fl = '0; lit_lat = 0;

    repeat (3) @(posedge clk);
    #1;
    post("reset_in_ready", 32'(bus.in_ready), 32'd1);
    post("reset_out_valid", 32'(bus.out_valid), 32'd0);
    post("reset_result", 32'(bus.result), 32'd0);
    post("reset_flags", 32'({bus.flag_overflow, bus.flag_underflow, bus.flag_inexact}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    //      s  exp  mant          sp spv       lit result    flags   lat hold
    do_op(0,  15, 22'h100000, 0, 16'h0, 1, 16'h3C00, 3'b000, 3, 0);  // 1.0 x 1.0
    do_op(0,  15, 22'h240000, 0, 16'h0, 1, 16'h4080, 3'b000, 4, 0);  // 1.5 x 1.5
    do_op(0,  30, 22'h300000, 0, 16'h0, 1, 16'h7C00, 3'b101, 4, 0);  // overflow
    do_op(1,  30, 22'h300000, 0, 16'h0, 1, 16'hFC00, 3'b101, 4, 0);  // -overflow
    do_op(0,  -4, 22'h100000, 0, 16'h0, 1, 16'h0020, 3'b000, 8, 0);  // exact subnormal
    do_op(0,  -4, 22'h100001, 0, 16'h0, 1, 16'h0020, 3'b011, 8, 0);  // inexact subnormal
    do_op(0,  15, 22'h100600, 0, 16'h0, 1, 16'h3C02, 3'b001, 3, 0);  // tie, odd -> up
    do_op(0,  15, 22'h100200, 0, 16'h0, 1, 16'h3C00, 3'b001, 3, 0);  // tie, even -> stay
    do_op(0,  15, 22'h080000, 0, 16'h0, 1, 16'h3800, 3'b000, 4, 0);  // one left shift
    do_op(1,  10, 22'h000000, 0, 16'h0, 1, 16'h8000, 3'b000, 3, 0);  // signed zero
    do_op(0,  30, 22'h1FFE00, 0, 16'h0, 1, 16'h7C00, 3'b101, 3, 0);  // round carry overflow
    do_op(0,  40, 22'h000001, 0, 16'h0, 1, 16'h5000, 3'b000, 23, 0); // 20 left shifts
    do_op(0,   0, 22'h000000, 1, 16'h7E00, 1, 16'h7E00, 3'b000, 1, 0); // bypass NaN
    do_op(0,  20, 22'h0C3A51, 0, 16'h0, 0, 16'h0, 3'b000, 0, 0);
    do_op(1,   2, 22'h00ABCD, 0, 16'h0, 0, 16'h0, 3'b000, 0, 0);
    do_op(0, -10, 22'h3FFFFF, 0, 16'h0, 0, 16'h0, 3'b000, 0, 0);
    do_op(1,  63, 22'h3FFFFF, 0, 16'h0, 0, 16'h0, 3'b000, 0, 0);
    do_op(0,  15, 22'h240000, 0, 16'h0, 1, 16'h4080, 3'b000, 4, 10); // held output

    // Abort an operation while it is still normalising.
    lit_en = 1'b0;
    offer(0, -4, 22'h100000, 0, 16'h0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    post("abort_out_valid", 32'(bus.out_valid), 32'd0);
    post("abort_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    do_op(0,  15, 22'h100600, 0, 16'h0, 1, 16'h3C02, 3'b001, 3, 0);

    repeat (3) @(posedge clk);
    #1;
    if (exp_q.size() != 0) post("results_outstanding", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
